uart_tx_scheduler: RTL

//  Shares the single UART transmit path (controller + shift register) between NUM_REQ requesters, e.g. switch/pushbutton send and RX echo.

---
 rtl/uart_tx_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmit path among NUM_REQ requesters.
// Define UART_SCHED_FIXED_PRIO_EN for fixed priority (lowest index always wins).
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 2,
  parameter int GAP_CYCLES   = 1302,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_start,
  output logic [6:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 sched_busy,
  output logic                 timeout
);

  localparam int MAX_CNT = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_start_q, tx_start_d;
  logic [6:0]         tx_data_q, tx_data_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic               sched_busy_q, sched_busy_d;
  logic               timeout_q, timeout_d;

  logic [6:0]         req_chars [NUM_REQ];
  logic [PTR_W-1:0]   winner;
  logic               grant_valid;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chars
      assign req_chars[gi] = req_data[7*gi +: 7];
    end
  endgenerate

  assign grant_valid = |req;

`ifdef UART_SCHED_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = PTR_W'(i);
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign rr_ptr_d = (state_q == S_IDLE && grant_valid) ? winner : rr_ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr_q <= PTR_W'(NUM_REQ - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      ack_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      sched_busy_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ack_q        <= ack_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      sched_busy_q <= sched_busy_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: if (grant_valid) state_d = S_START;
      S_START: begin
        state_d = S_WAIT_BUSY;
        timer_d = '0;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == BUSY_LAST) begin
          state_d = S_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_GAP;
          timer_d = '0;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) state_d = S_IDLE;
        else                     timer_d = timer_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers are loaded from state_q/state_d so every output is a flop.
  always_comb begin
    ack_d        = '0;
    tx_data_d    = tx_data_q;
    grant_id_d   = grant_id_q;
    tx_start_d   = (state_q == S_START);
    sched_busy_d = (state_d != S_IDLE);
    timeout_d    = (state_q == S_WAIT_BUSY) && !tx_busy && (timer_q == BUSY_LAST);
    if (state_q == S_IDLE && grant_valid) begin
      ack_d[winner] = 1'b1;
      tx_data_d     = req_chars[winner];
      grant_id_d    = 3'(winner);
    end
  end

  assign ack        = ack_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_id_q;
  assign sched_busy = sched_busy_q;
  assign timeout    = timeout_q;

endmodule
